mlp_seq_classifier: RTL and testbench

Time-multiplexed, parametrised successor to the fully-unrolled two-layer MLP classifier cores. One shared signed multiply-accumulate unit evaluates a fixed-weight N_IN→N_HID→N_OUT ReLU network, one product per cycle, and streams an argmax class plus raw output scores. Sits between the sensor/ADC front end (valid/ready in) and the decision consumer (valid/ready out). It trades latency for area and replaces silent activation truncation with saturation.

---
 rtl/mlp_pkg.sv | 48 ++++
 rtl/mlp_mac_relu_sat.sv | 62 ++++++
 rtl/mlp_seq_classifier.sv | 214 +++++++++++++++++++++
 tb/tb_mlp_seq_classifier.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared constants for the sequential MLP classifier: default weights,
// FSM state encoding and width helper functions.
package mlp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_L0,
        S_L1,
        S_DONE
    } state_t;

    // Default network: 6 inputs -> 3 hidden -> 3 outputs.
    localparam int W0_DEF [3][6] = '{
        '{ 10,  20,  -5,  15,  25,  10},
        '{ 20, -30,  15, -25,  10, -20},
        '{ 30, -10,  20,  25, -12,  40}
    };
    localparam int B0_DEF [3] = '{28, -10, 83};

    localparam int W1_DEF [3][3] = '{
        '{  5,   7, -10},
        '{ 40,  -2,  40},
        '{ -3,  12,  -3}
    };
    localparam int B1_DEF [3] = '{15667, -12513, 1101};

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // clog2 that never returns a zero width
    function automatic int clog2m(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Widest signed sum any neuron can reach, so the accumulator never wraps.
    function automatic int acc_width(
        input int in_w,
        input int act_w,
        input int w_w,
        input int n_in,
        input int n_hid
    );
        return imax(in_w + 1, act_w + 1) + w_w
               + $clog2(imax(n_in, n_hid)) + 1;
    endfunction

endpackage

// File: rtl/mlp_mac_relu_sat.sv
// Shared signed MAC with bias load, ReLU and saturating clamp.
// Ports: i_clr/i_en/i_load control, i_x unsigned operand, i_w signed weight,
// i_bias pre-sized bias, i_l1 selects score clamp, o_res clamped next sum.
module mlp_mac_relu_sat #(
    parameter int X_W     = 12,
    parameter int W_W     = 8,
    parameter int ACC_W   = 25,
    parameter int ACT_W   = 12,
    parameter int SCORE_W = 19,
    parameter int RES_W   = (ACT_W > SCORE_W) ? ACT_W : SCORE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic                    i_l1,
    input  logic [X_W-1:0]          i_x,
    input  logic signed [W_W-1:0]   i_w,
    input  logic signed [ACC_W-1:0] i_bias,
    output logic [RES_W-1:0]        o_res
);

    localparam logic signed [ACC_W-1:0] ACT_MAX =
        ACC_W'((64'd1 << ACT_W) - 64'd1);
    localparam logic signed [ACC_W-1:0] SCORE_MAX =
        ACC_W'((64'd1 << SCORE_W) - 64'd1);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_lim;
    logic signed [ACC_W-1:0] w_sat;

    always_comb begin
        w_base = i_load ? i_bias : r_acc;
        // operand is unsigned, so a zero sign bit is prepended
        w_prod = ACC_W'($signed({1'b0, i_x})) * ACC_W'(i_w);
        w_sum  = w_base + w_prod;
        w_lim  = i_l1 ? SCORE_MAX : ACT_MAX;
        if (w_sum < 0) begin
            w_sat = '0;
        end else if (w_sum > w_lim) begin
            w_sat = w_lim;
        end else begin
            w_sat = w_sum;
        end
        o_res = RES_W'(w_sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed two-layer ReLU MLP classifier, one product per cycle.
// Ports: in_valid/in_ready/inp features in; out_valid/out_ready/out/predo result out.
module mlp_seq_classifier
    import mlp_pkg::*;
#(
    parameter int N_IN    = 6,
    parameter int IN_W    = 5,
    parameter int N_HID   = 3,
    parameter int N_OUT   = 3,
    parameter int W_W     = 8,
    parameter int ACT_W   = 12,
    parameter int SCORE_W = 19,
    parameter int W0 [N_HID][N_IN]  = W0_DEF,
    parameter int B0 [N_HID]        = B0_DEF,
    parameter int W1 [N_OUT][N_HID] = W1_DEF,
    parameter int B1 [N_OUT]        = B1_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*IN_W-1:0]       inp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_OUT)-1:0]   out,
    output logic [N_OUT*SCORE_W-1:0]   predo
);

    localparam int ACC_W = acc_width(IN_W, ACT_W, W_W, N_IN, N_HID);
    localparam int X_W   = imax(IN_W, ACT_W);
    localparam int RES_W = imax(ACT_W, SCORE_W);
    localparam int OW    = $clog2(N_OUT);
    localparam int CW    = clog2m(imax(imax(N_IN, N_HID), N_OUT));

    state_t                  r_state;
    logic [CW-1:0]           r_i;
    logic [CW-1:0]           r_j;
    logic [N_IN*IN_W-1:0]    r_inp;
    logic [ACT_W-1:0]        r_hid [N_HID];
    logic [SCORE_W-1:0]      r_score [N_OUT];
    logic [SCORE_W-1:0]      r_best;
    logic [OW-1:0]           r_idx;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [OW-1:0]           r_out;
    logic [N_OUT*SCORE_W-1:0] r_predo;

    logic [X_W-1:0]          w_x;
    logic signed [W_W-1:0]   w_wt;
    logic signed [ACC_W-1:0] w_bias;
    logic                    w_accept;
    logic                    w_busy;
    logic                    w_l1;
    logic                    w_last_j;
    logic                    w_last_i;
    logic [RES_W-1:0]        w_res;
    logic [SCORE_W-1:0]      w_new;
    logic                    w_better;
    logic [N_OUT*SCORE_W-1:0] w_predo_nxt;

    assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_l1     = (r_state == S_L1);
    assign w_busy   = (r_state == S_L0) || w_l1;
    assign w_new    = SCORE_W'(w_res);
    // first score always loads; later ones need a strict win
    assign w_better = (r_i == '0) || (w_new > r_best);

    // Operand, weight and bias selection for the current (i, j) step.
    always_comb begin
        w_x      = '0;
        w_wt     = '0;
        w_bias   = '0;
        w_last_j = 1'b0;
        w_last_i = 1'b0;
        if (w_l1) begin
            w_last_j = int'(r_j) == N_HID - 1;
            w_last_i = int'(r_i) == N_OUT - 1;
            for (int h = 0; h < N_HID; h++) begin
                if (int'(r_j) == h) w_x = X_W'(r_hid[h]);
            end
            for (int o = 0; o < N_OUT; o++) begin
                if (int'(r_i) == o) w_bias = ACC_W'(B1[o]);
                for (int h = 0; h < N_HID; h++) begin
                    if (int'(r_i) == o && int'(r_j) == h)
                        w_wt = W_W'(W1[o][h]);
                end
            end
        end else begin
            w_last_j = int'(r_j) == N_IN - 1;
            w_last_i = int'(r_i) == N_HID - 1;
            for (int k = 0; k < N_IN; k++) begin
                if (int'(r_j) == k) w_x = X_W'(r_inp[k*IN_W +: IN_W]);
            end
            for (int h = 0; h < N_HID; h++) begin
                if (int'(r_i) == h) w_bias = ACC_W'(B0[h]);
                for (int k = 0; k < N_IN; k++) begin
                    if (int'(r_i) == h && int'(r_j) == k)
                        w_wt = W_W'(W0[h][k]);
                end
            end
        end
    end

    // Final score vector: the last score arrives on the DONE-entry edge.
    always_comb begin
        w_predo_nxt = '0;
        for (int o = 0; o < N_OUT; o++) begin
            w_predo_nxt[(N_OUT-1-o)*SCORE_W +: SCORE_W] =
                (o == N_OUT - 1) ? w_new : r_score[o];
        end
    end

    mlp_mac_relu_sat #(
        .X_W     (X_W),
        .W_W     (W_W),
        .ACC_W   (ACC_W),
        .ACT_W   (ACT_W),
        .SCORE_W (SCORE_W),
        .RES_W   (RES_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_en   (w_busy),
        .i_load (r_j == '0),
        .i_l1   (w_l1),
        .i_x    (w_x),
        .i_w    (w_wt),
        .i_bias (w_bias),
        .o_res  (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_inp       <= '0;
            r_best      <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_predo     <= '0;
            for (int h = 0; h < N_HID; h++) r_hid[h] <= '0;
            for (int o = 0; o < N_OUT; o++) r_score[o] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_inp      <= inp;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_L0;
                    end
                end
                S_L0: begin
                    if (w_last_j) begin
                        r_j <= '0;
                        for (int h = 0; h < N_HID; h++) begin
                            if (int'(r_i) == h) r_hid[h] <= ACT_W'(w_res);
                        end
                        if (w_last_i) begin
                            r_i     <= '0;
                            r_state <= S_L1;
                        end else begin
                            r_i <= r_i + CW'(1);
                        end
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end
                S_L1: begin
                    if (w_last_j) begin
                        r_j <= '0;
                        for (int o = 0; o < N_OUT; o++) begin
                            if (int'(r_i) == o) r_score[o] <= w_new;
                        end
                        if (w_better) begin
                            r_best <= w_new;
                            r_idx  <= OW'(r_i);
                        end
                        if (w_last_i) begin
                            r_i         <= '0;
                            r_out       <= w_better ? OW'(r_i) : r_idx;
                            r_predo     <= w_predo_nxt;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_i <= r_i + CW'(1);
                        end
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign predo     = r_predo;

endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Self-checking bench: three classifier variants driven in lockstep and
// compared against a plain-arithmetic network model and directed vectors.
module tb_mlp_seq_classifier;
    import mlp_pkg::*;

    localparam int N_IN  = 6;
    localparam int N_OUT = 3;
    localparam int SW    = 19;
    localparam int LAT   = 3 * 6 + 3 * 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] inp = '0;

    logic        rdy   [3];
    logic        vld   [3];
    logic [1:0]  cls_o [3];
    logic [56:0] pr    [3];

    int checks = 0;
    int failures = 0;

    longint m_hid [3][3];
    longint m_sc  [3][3];
    int     m_cls [3];

    always #5 clk = ~clk;

    mlp_seq_classifier u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .inp(inp), .out_valid(vld[0]), .out_ready(out_ready),
        .out(cls_o[0]), .predo(pr[0])
    );

    mlp_seq_classifier #(.ACT_W(8)) u_a8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .inp(inp), .out_valid(vld[1]), .out_ready(out_ready),
        .out(cls_o[1]), .predo(pr[1])
    );

    mlp_seq_classifier #(
        .W1('{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}}),
        .B1('{5, 5, 5})
    ) u_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .inp(inp), .out_valid(vld[2]), .out_ready(out_ready),
        .out(cls_o[2]), .predo(pr[2])
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint dsc(input int v, input int o);
        return longint'(pr[v][(N_OUT-1-o)*SW +: SW]);
    endfunction

    function automatic longint dhid(input int v, input int h);
        case (v)
            0:       return longint'(u_def.r_hid[h]);
            1:       return longint'(u_a8.r_hid[h]);
            default: return longint'(u_z.r_hid[h]);
        endcase
    endfunction

    // Network evaluated straight from its definition for each variant:
    // 0 = defaults, 1 = 8-bit activations, 2 = zero W1 with bias 5.
    task automatic model_all(input logic [29:0] x);
        longint a;
        longint amax;
        for (int v = 0; v < 3; v++) begin
            amax = (v == 1) ? 255 : 4095;
            for (int h = 0; h < 3; h++) begin
                a = B0_DEF[h];
                for (int k = 0; k < N_IN; k++)
                    a += longint'(x[k*5 +: 5]) * W0_DEF[h][k];
                if (a < 0) a = 0;
                if (a > amax) a = amax;
                m_hid[v][h] = a;
            end
            for (int o = 0; o < 3; o++) begin
                a = (v == 2) ? 5 : B1_DEF[o];
                for (int h = 0; h < 3; h++)
                    a += m_hid[v][h] * ((v == 2) ? 0 : W1_DEF[o][h]);
                if (a < 0) a = 0;
                if (a > 524287) a = 524287;
                m_sc[v][o] = a;
            end
            m_cls[v] = 0;
            for (int o = 1; o < 3; o++)
                if (m_sc[v][o] > m_sc[v][m_cls[v]]) m_cls[v] = o;
        end
    endtask

    task automatic check_model(input string tag, input logic [29:0] x);
        model_all(x);
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("%s v%0d valid", tag, v), vld[v], 1);
            for (int o = 0; o < 3; o++)
                chk($sformatf("%s v%0d score%0d", tag, v, o),
                    dsc(v, o), m_sc[v][o]);
            chk($sformatf("%s v%0d class", tag, v), cls_o[v], m_cls[v]);
        end
    endtask

    // Accept x, then wait for out_valid; latency is counted in edges
    // after the accept edge (27 edges puts out_valid in cycle 28).
    task automatic run_inf(input string tag, input logic [29:0] x);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready idle"}, rdy[0], 1);
        in_valid = 1'b1;
        inp = x;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " in_ready busy"}, rdy[0], 0);
        lat = 0;
        while (!vld[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, LAT);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop"}, vld[0], 0);
        chk({tag, " in_ready back"}, rdy[0], 1);
    endtask

    typedef struct {
        int          v;
        logic [29:0] x;
        int          h0, h1, h2;
        int          s0, s1, s2;
        int          c;
    } row_t;

    row_t        tbl [6];
    logic [29:0] xa, xb, xr;
    longint      held [3];
    logic [1:0]  held_c;

    initial begin
        tbl[0] = '{0, 30'd0,          28,   0,   83, 14977,      0, 768, 0};
        tbl[1] = '{0, 30'h3FFF_FFFF, 2353,  0, 2966,     0, 200247,   0, 1};
        tbl[2] = '{1, 30'h3FFF_FFFF,  255,  0,  255, 14392,   7887,   0, 0};
        tbl[3] = '{1, 30'd0,           28,  0,   83, 14977,      0, 768, 0};
        tbl[4] = '{2, 30'd0,           28,  0,   83,     5,      5,   5, 0};
        tbl[5] = '{2, 30'h3FFF_FFFF, 2353,  0, 2966,     5,      5,   5, 0};

        repeat (3) @(negedge clk);
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("reset v%0d out_valid", v), vld[v], 0);
            chk($sformatf("reset v%0d predo", v), longint'(pr[v]), 0);
            chk($sformatf("reset v%0d out", v), cls_o[v], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset release in_ready", rdy[0], 1);

        for (int r = 0; r < 6; r++) begin
            run_inf($sformatf("tbl%0d", r), tbl[r].x);
            chk($sformatf("tbl%0d hid0", r), dhid(tbl[r].v, 0), tbl[r].h0);
            chk($sformatf("tbl%0d hid1", r), dhid(tbl[r].v, 1), tbl[r].h1);
            chk($sformatf("tbl%0d hid2", r), dhid(tbl[r].v, 2), tbl[r].h2);
            chk($sformatf("tbl%0d s0", r), dsc(tbl[r].v, 0), tbl[r].s0);
            chk($sformatf("tbl%0d s1", r), dsc(tbl[r].v, 1), tbl[r].s1);
            chk($sformatf("tbl%0d s2", r), dsc(tbl[r].v, 2), tbl[r].s2);
            chk($sformatf("tbl%0d class", r), cls_o[tbl[r].v], tbl[r].c);
            handshake($sformatf("tbl%0d", r));
        end

        for (int n = 0; n < 20; n++) begin
            xr = 30'($urandom());
            run_inf($sformatf("rnd%0d", n), xr);
            check_model($sformatf("rnd%0d", n), xr);
            handshake($sformatf("rnd%0d", n));
        end

        // Result held while the consumer stalls; a new request is ignored.
        xa = 30'($urandom());
        xb = ~xa;
        run_inf("hold", xa);
        for (int o = 0; o < 3; o++) held[o] = dsc(0, o);
        held_c = cls_o[0];
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 4);
            inp = xb;
            @(negedge clk);
            chk($sformatf("hold%0d valid", c), vld[0], 1);
            chk($sformatf("hold%0d in_ready", c), rdy[0], 0);
            chk($sformatf("hold%0d s0", c), dsc(0, 0), held[0]);
            chk($sformatf("hold%0d s1", c), dsc(0, 1), held[1]);
            chk($sformatf("hold%0d s2", c), dsc(0, 2), held[2]);
            chk($sformatf("hold%0d class", c), cls_o[0], held_c);
        end
        in_valid = 1'b0;
        check_model("hold final", xa);
        handshake("hold");
        @(negedge clk);
        chk("hold no restart", rdy[0], 1);
        run_inf("after hold", xb);
        check_model("after hold", xb);
        handshake("after hold");

        // Asynchronous reset part-way through an inference.
        @(negedge clk);
        in_valid = 1'b1;
        inp = 30'($urandom());
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("midrst v%0d valid", v), vld[v], 0);
            chk($sformatf("midrst v%0d predo", v), longint'(pr[v]), 0);
            chk($sformatf("midrst v%0d out", v), cls_o[v], 0);
        end
        chk("midrst hid0", dhid(0, 0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst in_ready", rdy[0], 1);
        chk("midrst still idle", vld[0], 0);
        xr = 30'($urandom());
        run_inf("post rst", xr);
        check_model("post rst", xr);
        handshake("post rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
